// File: rtl/contador_m_ud_if.sv
// Request/status bundle for the runtime-programmable up/down modulo counter.
// The control unit drives the requests through master; the counter uses slave.
interface contador_m_ud_if #(
  parameter int N = 7
);
  logic         zera_s;
  logic         define_m;
  logic [N-1:0] M_in;
  logic         carrega;
  logic [N-1:0] D;
  logic         conta;
  logic         sentido;
  logic         modo;
  logic [N-1:0] Q;
  logic [N-1:0] M_atual;
  logic         fim;
  logic         meio;
  logic         saturado;
  logic         erro;

  modport master (
    output zera_s, define_m, M_in, carrega, D, conta, sentido, modo,
    input  Q, M_atual, fim, meio, saturado, erro
  );

  modport slave (
    input  zera_s, define_m, M_in, carrega, D, conta, sentido, modo,
    output Q, M_atual, fim, meio, saturado, erro
  );
endinterface

// File: rtl/contador_m_ud.sv
// Up/down modulo counter with runtime modulus, parallel load, wrap/saturate
// modes, and registered terminal/mid pulses plus saturation and error flags.
module contador_m_ud #(
  parameter int N = 7,
  parameter int M = 100
) (
  input  logic              clock,
  input  logic              zera_as_n,
  contador_m_ud_if.slave    bus
);

  localparam logic [N-1:0] ZERO  = '0;
  localparam logic [N-1:0] ONE   = N'(1);
  localparam logic [N-1:0] TWO   = N'(2);
  localparam logic [N-1:0] M_RST = N'(M);

  logic [N-1:0] q_q, q_d;
  logic [N-1:0] m_q, m_d;
  logic         fim_q, fim_d;
  logic         meio_q, meio_d;
  logic         sat_q, sat_d;
  logic         erro_q, erro_d;

  // Terminal and mid values depend on direction; both are derived from the
  // modulus in force during the step.
  logic [N-1:0] term;
  logic [N-1:0] mid;

  always_comb begin
    term = bus.sentido ? ZERO : (m_q - ONE);
    mid  = bus.sentido ? (m_q >> 1) : ((m_q >> 1) - ONE);
  end

  // Only the highest-priority request acts each cycle:
  // zera_s > define_m > carrega > conta > idle.
  always_comb begin
    q_d    = q_q;
    m_d    = m_q;
    fim_d  = 1'b0;
    meio_d = 1'b0;
    sat_d  = sat_q;
    erro_d = erro_q;

    if (bus.zera_s) begin
      q_d    = ZERO;
      sat_d  = 1'b0;
      erro_d = 1'b0;
    end else if (bus.define_m) begin
      if (bus.M_in < TWO) begin
        erro_d = 1'b1;
      end else begin
        m_d   = bus.M_in;
        sat_d = 1'b0;
        if (q_q >= bus.M_in) begin
          q_d = ZERO;
        end
      end
    end else if (bus.carrega) begin
      if (bus.D >= m_q) begin
        erro_d = 1'b1;
      end else begin
        q_d   = bus.D;
        sat_d = 1'b0;
      end
    end else if (bus.conta) begin
      meio_d = (q_q == mid);
      if (q_q == term) begin
        fim_d = 1'b1;
        if (bus.modo) begin
          sat_d = 1'b1;
        end else begin
          q_d   = bus.sentido ? (m_q - ONE) : ZERO;
          sat_d = 1'b0;
        end
      end else begin
        q_d   = bus.sentido ? (q_q - ONE) : (q_q + ONE);
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      q_q    <= ZERO;
      m_q    <= M_RST;
      fim_q  <= 1'b0;
      meio_q <= 1'b0;
      sat_q  <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      m_q    <= m_d;
      fim_q  <= fim_d;
      meio_q <= meio_d;
      sat_q  <= sat_d;
      erro_q <= erro_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.M_atual  = m_q;
  assign bus.fim      = fim_q;
  assign bus.meio     = meio_q;
  assign bus.saturado = sat_q;
  assign bus.erro     = erro_q;

endmodule
